// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder used as the serial datapath cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] b_cpl;
  logic [WIDTH-1:0] res_next;
  logic             bit_s;
  logic             bit_c;

  // Operand B is conditionally inverted at capture; carry-in = m completes the negation.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cpl
      assign b_cpl[gi] = b[gi] ^ m;
    end
  endgenerate

  fa_bit u_fa (
    .a    (opa_reg[0]),
    .b    (opb_reg[0]),
    .cin  (carry_reg),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign res_next = {bit_s, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        RUN: begin
          res_reg   <= res_next;
          opa_reg   <= opa_reg >> 1;
          opb_reg   <= opb_reg >> 1;
          carry_reg <= bit_c;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          // MSB step: carry_reg still holds the carry into the MSB.
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= DONE;
            done      <= 1'b1;
            sum       <= res_next;
            cout      <= bit_c;
            ovf       <= carry_reg ^ bit_c;
            zero      <= (res_next == '0);
          end
        end
        default: begin
          // The DONE cycle also accepts start so a held start yields WIDTH+1 cycle throughput.
          if (start) begin
            state_reg <= RUN;
            opa_reg   <= a;
            opb_reg   <= b_cpl;
            carry_reg <= (m == MODE_SUB);
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial at WIDTH=4 and WIDTH=8.
module tb_addsub_serial;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, m4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4, zero4;
  logic [3:0] sum4;

  logic       start8 = 1'b0, m8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8, zero8;
  logic [7:0] sum8;

  addsub_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .m(m4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  addsub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .m(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and signed values.
  function automatic exp_t model(input int w, input logic mm, input logic [7:0] aa, input logic [7:0] bb);
    exp_t e;
    int mask, half, ua, ub, sa, sb, r, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua = int'(aa) & mask;
    ub = int'(bb) & mask;
    sa = (ua >= half) ? ua - (1 << w) : ua;
    sb = (ub >= half) ? ub - (1 << w) : ub;
    r  = mm ? ua - ub : ua + ub;
    sr = mm ? sa - sb : sa + sb;
    e.sum  = 8'(r & mask);
    e.cout = mm ? (ua >= ub) : (ua + ub > mask);
    e.ovf  = (sr < -half) || (sr > half - 1);
    e.zero = ((r & mask) == 0);
    e.cyc  = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.cyc = 0;
    return e;
  endfunction

  // Monitors: pop the oldest expectation whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL w4_unexpected_done: got done with sum %0d, expected no done", sum4);
      end else begin
        e4 = q4.pop_front();
        chk("w4_sum", 32'(sum4), 32'(e4.sum[3:0]));
        chk("w4_cout", 32'(cout4), 32'(e4.cout));
        chk("w4_ovf", 32'(ovf4), 32'(e4.ovf));
        chk("w4_zero", 32'(zero4), 32'(e4.zero));
        chk("w4_latency", 32'(cyc - e4.cyc), 32'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL w8_unexpected_done: got done with sum %0d, expected no done", sum8);
      end else begin
        e8 = q8.pop_front();
        chk("w8_sum", 32'(sum8), 32'(e8.sum));
        chk("w8_cout", 32'(cout8), 32'(e8.cout));
        chk("w8_ovf", 32'(ovf8), 32'(e8.ovf));
        chk("w8_zero", 32'(zero8), 32'(e8.zero));
        chk("w8_latency", 32'(cyc - e8.cyc), 32'd8);
      end
    end
  end

  // One-cycle start pulse; the expectation is timestamped with the accepting edge.
  task automatic pulse(input int d, input logic mm, input logic [7:0] aa, input logic [7:0] bb,
                       input bit push, input exp_t e);
    @(negedge clk);
    if (d == 4) begin start4 = 1'b1; m4 = mm; a4 = aa[3:0]; b4 = bb[3:0]; end
    else        begin start8 = 1'b1; m8 = mm; a8 = aa;      b8 = bb;      end
    @(posedge clk);
    #1;
    e.cyc = cyc;
    if (push) begin
      if (d == 4) q4.push_back(e);
      else        q8.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    // Operands are don't-care after capture.
    a4 = 4'($urandom); b4 = 4'($urandom); m4 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((((d == 4) ? busy4 : busy8) !== 1'b0) && k < 40);
    if (k >= 40) begin
      n_vec++; n_bad++;
      $display("FAIL w%0d_idle_timeout: busy still high after %0d cycles, expected low", d, k);
    end
  endtask

  task automatic hold_chk(input int d, input logic [7:0] s);
    @(negedge clk);
    if (d == 4) chk("w4_hold", 32'(sum4), 32'(s[3:0]));
    else        chk("w8_hold", 32'(sum8), 32'(s));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t, d;
    logic mm;
    logic [7:0] aa, bb;

    repeat (3) @(negedge clk);
    chk("rst_w4_outputs", 32'({busy4, done4, sum4, cout4, ovf4, zero4}), 32'd0);
    chk("rst_w8_outputs", 32'({busy8, done8, sum8, cout8, ovf8, zero8}), 32'd0);
    rst_n = 1'b1;

    // Directed WIDTH=4 cases
    pulse(4, 1'b0, 8'd3, 8'd5, 1'b1, mk(8'd8, 1'b0, 1'b1, 1'b0));
    wait_idle(4); hold_chk(4, 8'd8);
    pulse(4, 1'b1, 8'd5, 8'd5, 1'b1, mk(8'd0, 1'b1, 1'b0, 1'b1));
    wait_idle(4); hold_chk(4, 8'd0);
    pulse(4, 1'b1, 8'd2, 8'd3, 1'b1, mk(8'd15, 1'b0, 1'b0, 1'b0));
    wait_idle(4); hold_chk(4, 8'd15);
    pulse(4, 1'b1, 8'd8, 8'd1, 1'b1, mk(8'd7, 1'b1, 1'b1, 1'b0));
    wait_idle(4); hold_chk(4, 8'd7);

    // start during RUN is ignored
    pulse(4, 1'b0, 8'd6, 8'd7, 1'b1, mk(8'd13, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    start4 = 1'b1; m4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    chk("w4_busy_in_run", 32'(busy4), 32'd1);
    @(negedge clk);
    start4 = 1'b0;
    wait_idle(4); hold_chk(4, 8'd13);

    // reset mid-operation: immediate clear, no done
    pulse(4, 1'b0, 8'd3, 8'd3, 1'b0, mk(8'd6, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("w4_async_reset", 32'({busy4, done4, sum4, cout4, ovf4, zero4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("w4_idle_after_reset", 32'({busy4, done4}), 32'd0);
    pulse(4, 1'b0, 8'd1, 8'd1, 1'b1, mk(8'd2, 1'b0, 1'b0, 1'b0));
    wait_idle(4); hold_chk(4, 8'd2);

    // Directed WIDTH=8
    pulse(8, 1'b0, 8'd200, 8'd100, 1'b1, mk(8'd44, 1'b1, 1'b0, 1'b0));
    wait_idle(8); hold_chk(8, 8'd44);

    // start held high: back-to-back every WIDTH+1 cycles
    @(negedge clk);
    start8 = 1'b1; m8 = 1'b0; a8 = 8'd200; b8 = 8'd100;
    @(posedge clk);
    #1;
    t = cyc;
    e = mk(8'd44, 1'b1, 1'b0, 1'b0);
    e.cyc = t;     q8.push_back(e);
    e.cyc = t + 9; q8.push_back(e);
    repeat (12) @(negedge clk);
    start8 = 1'b0;
    wait_idle(8);

    // Randomized operations on both widths
    for (int i = 0; i < 24; i++) begin
      d  = (i % 2 == 0) ? 4 : 8;
      mm = 1'($urandom);
      aa = 8'($urandom);
      bb = 8'($urandom);
      e  = model(d, mm, aa, bb);
      pulse(d, mm, aa, bb, 1'b1, e);
      wait_idle(d);
      hold_chk(d, e.sum);
    end

    repeat (5) @(negedge clk);
    chk("w4_pending_results", 32'(q4.size()), 32'd0);
    chk("w8_pending_results", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
